mem_port_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between the IF stage (instruction fetch, read-only) and the MEM stage (loads and stores) of the RV32I pipeline. It grants one requester at a time, steers bytes for sub-word accesses, and sign- or zero-extends load data. It stalls whichever stage is waiting. It sits between the pipeline and the unified memory model.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_defs_pkg.sv | 11 +
 rtl/mem_lane_steer.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DATA,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

endpackage

// File: rtl/mem_defs_pkg.sv
// Shared memory access encodings: access size codes and load sign codes.
package mem_defs_pkg;

  localparam logic [2:0] Byte = 3'd0;
  localparam logic [2:0] Half = 3'd1;
  localparam logic [2:0] Word = 3'd2;

  localparam logic Signed   = 1'b1;
  localparam logic Unsigned = 1'b0;

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational lane steering: byte enables and store replication for the
// outgoing access, lane select plus sign/zero extension for load data.
module mem_lane_steer
  import mem_defs_pkg::*;
  import mem_arb_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
  end

  // Half accesses ignore lane_i[0]; only the upper/lower half is selectable.
  assign half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      Byte: begin
        be_o    = BE_BYTE << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (sign_i == Signed) ? {{24{byte_sel[7]}}, byte_sel}
                                     : {24'd0, byte_sel};
      end
      Half: begin
        be_o    = BE_HALF << {lane_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (sign_i == Signed) ? {{16{half_sel[15]}}, half_sel}
                                     : {16'd0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and
// the data stage. Optional MISALIGN_CHECK_EN rejects misaligned data accesses.
//
//   state    | meaning
//   ST_IDLE  | no access in flight; grant data first, then fetch
//   ST_FETCH | word read for IF outstanding, Mem_req_o held
//   ST_DATA  | load/store for MEM outstanding, Mem_req_o held
//   ST_RESP  | owner's valid pulses; no grant this cycle
module mem_port_arbiter
  import mem_defs_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              IF_req_i,
  input  logic [ADDR_W-1:0] IF_addr_i,
  output logic              IF_valid_o,
  output logic [31:0]       IF_rdata_o,
  input  logic              MEM_req_i,
  input  logic              MEM_we_i,
  input  logic [ADDR_W-1:0] MEM_addr_i,
  input  logic [2:0]        MEM_size_i,
  input  logic              MEM_sign_i,
  input  logic [31:0]       MEM_wdata_i,
  output logic              MEM_valid_o,
  output logic [31:0]       MEM_rdata_o,
  output logic              Misalign_o,
  output logic              Stall_IF_o,
  output logic              Stall_MEM_o,
  output logic              Mem_req_o,
  output logic              Mem_we_o,
  output logic [3:0]        Mem_be_o,
  output logic [ADDR_W-1:0] Mem_addr_o,
  output logic [31:0]       Mem_wdata_o,
  input  logic [31:0]       Mem_rdata_i,
  input  logic              Mem_ready_i
);

  arb_state_e        state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [2:0]        size_q;
  logic              sign_q;
  logic [1:0]        lane_q;
  logic              mem_req_q;
  logic              if_valid_q;
  logic              mem_valid_q;
  logic [31:0]       if_rdata_q;
  logic [31:0]       mem_rdata_q;

  logic [2:0]  st_size;
  logic        st_sign;
  logic [1:0]  st_lane;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] st_rdata;
  logic        misalign_now;
  logic        if_addr_unused;

  assign if_addr_unused = ^IF_addr_i[1:0];

  // In IDLE the steer shapes the incoming request; afterwards it extends load data.
  assign st_size = (state_q == ST_IDLE) ? MEM_size_i       : size_q;
  assign st_sign = (state_q == ST_IDLE) ? MEM_sign_i       : sign_q;
  assign st_lane = (state_q == ST_IDLE) ? MEM_addr_i[1:0]  : lane_q;

  mem_lane_steer u_steer (
    .size_i  (st_size),
    .sign_i  (st_sign),
    .lane_i  (st_lane),
    .wdata_i (MEM_wdata_i),
    .rdata_i (Mem_rdata_i),
    .be_o    (st_be),
    .wdata_o (st_wdata),
    .rdata_o (st_rdata)
  );

`ifdef MISALIGN_CHECK_EN
  logic misalign_q;
  assign misalign_now = ((MEM_size_i == Word) && (MEM_addr_i[1:0] != 2'b00)) ||
                        ((MEM_size_i == Half) && MEM_addr_i[0]);
  assign Misalign_o   = misalign_q;
`else
  assign misalign_now = 1'b0;
  assign Misalign_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      lane_q      <= '0;
      mem_req_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (MEM_req_i) begin
            owner_q <= OWN_MEM;
            addr_q  <= {MEM_addr_i[ADDR_W-1:2], 2'b00};
            we_q    <= MEM_we_i;
            be_q    <= st_be;
            wdata_q <= MEM_we_i ? st_wdata : 32'd0;
            size_q  <= MEM_size_i;
            sign_q  <= MEM_sign_i;
            lane_q  <= MEM_addr_i[1:0];
            if (misalign_now) begin
              state_q     <= ST_RESP;
              mem_valid_q <= 1'b1;
              mem_rdata_q <= '0;
`ifdef MISALIGN_CHECK_EN
              misalign_q  <= 1'b1;
`endif
            end else begin
              state_q   <= ST_DATA;
              mem_req_q <= 1'b1;
            end
          end else if (IF_req_i) begin
            owner_q   <= OWN_IF;
            addr_q    <= {IF_addr_i[ADDR_W-1:2], 2'b00};
            we_q      <= 1'b0;
            be_q      <= BE_WORD;
            wdata_q   <= '0;
            state_q   <= ST_FETCH;
            mem_req_q <= 1'b1;
          end
        end
        ST_FETCH, ST_DATA: begin
          if (Mem_ready_i) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_RESP;
            if (owner_q == OWN_IF) begin
              if_rdata_q <= Mem_rdata_i;
              if_valid_q <= 1'b1;
            end else begin
              mem_rdata_q <= we_q ? 32'd0 : st_rdata;
              mem_valid_q <= 1'b1;
            end
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign IF_valid_o  = if_valid_q;
  assign IF_rdata_o  = if_rdata_q;
  assign MEM_valid_o = mem_valid_q;
  assign MEM_rdata_o = mem_rdata_q;
  assign Mem_req_o   = mem_req_q;
  assign Mem_we_o    = we_q;
  assign Mem_be_o    = be_q;
  assign Mem_addr_o  = addr_q;
  assign Mem_wdata_o = wdata_q;
  assign Stall_IF_o  = IF_req_i & ~IF_valid_o;
  assign Stall_MEM_o = MEM_req_i & ~MEM_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; honours MISALIGN_CHECK_EN.
module tb_mem_port_arbiter;
  import mem_defs_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              IF_req_i;
  logic [ADDR_W-1:0] IF_addr_i;
  logic              IF_valid_o;
  logic [31:0]       IF_rdata_o;
  logic              MEM_req_i;
  logic              MEM_we_i;
  logic [ADDR_W-1:0] MEM_addr_i;
  logic [2:0]        MEM_size_i;
  logic              MEM_sign_i;
  logic [31:0]       MEM_wdata_i;
  logic              MEM_valid_o;
  logic [31:0]       MEM_rdata_o;
  logic              Misalign_o;
  logic              Stall_IF_o;
  logic              Stall_MEM_o;
  logic              Mem_req_o;
  logic              Mem_we_o;
  logic [3:0]        Mem_be_o;
  logic [ADDR_W-1:0] Mem_addr_o;
  logic [31:0]       Mem_wdata_o;
  logic [31:0]       Mem_rdata_i;
  logic              Mem_ready_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IF_req_i(IF_req_i), .IF_addr_i(IF_addr_i),
    .IF_valid_o(IF_valid_o), .IF_rdata_o(IF_rdata_o),
    .MEM_req_i(MEM_req_i), .MEM_we_i(MEM_we_i), .MEM_addr_i(MEM_addr_i),
    .MEM_size_i(MEM_size_i), .MEM_sign_i(MEM_sign_i), .MEM_wdata_i(MEM_wdata_i),
    .MEM_valid_o(MEM_valid_o), .MEM_rdata_o(MEM_rdata_o), .Misalign_o(Misalign_o),
    .Stall_IF_o(Stall_IF_o), .Stall_MEM_o(Stall_MEM_o),
    .Mem_req_o(Mem_req_o), .Mem_we_o(Mem_we_o), .Mem_be_o(Mem_be_o),
    .Mem_addr_o(Mem_addr_o), .Mem_wdata_o(Mem_wdata_o),
    .Mem_rdata_i(Mem_rdata_i), .Mem_ready_i(Mem_ready_i)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
  } mresp_t;

  mresp_t      mem_q[$];
  logic [31:0] if_q[$];
  mresp_t      mon_e;
  logic [31:0] mon_w;

  int checks   = 0;
  int failures = 0;

  // Memory model state
  logic [31:0] mem_img [logic [31:0]];
  int          mem_wait = 0;
  int          wait_cnt = 0;
  int          wr_cnt   = 0;
  logic        last_we;
  logic [3:0]  last_be;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;

  // {MEM_valid, IF_valid, Mem_req, Stall_IF, Stall_MEM} per cycle, both requests together
  logic [4:0] both_exp [6] = '{5'b00011, 5'b00111, 5'b10010, 5'b00010, 5'b00110, 5'b01000};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_ctrl"}, {26'd0, IF_valid_o, MEM_valid_o, Misalign_o, Mem_req_o, Mem_we_o, |Mem_be_o}, 32'd0);
    chk({tag, "_addr"}, Mem_addr_o, 32'd0);
    chk({tag, "_wdata"}, Mem_wdata_o, 32'd0);
    chk({tag, "_if_rdata"}, IF_rdata_o, 32'd0);
    chk({tag, "_mem_rdata"}, MEM_rdata_o, 32'd0);
  endtask

  // Memory model: ready after mem_wait wait cycles of a held request.
  initial begin
    Mem_ready_i = 1'b0;
    Mem_rdata_i = 32'd0;
    forever begin
      @(negedge clk_i);
      Mem_ready_i = 1'b0;
      if (Mem_req_o && !rst_i) begin
        if (wait_cnt >= mem_wait) begin
          Mem_ready_i = 1'b1;
          Mem_rdata_i = mem_img.exists(Mem_addr_o) ? mem_img[Mem_addr_o] : 32'd0;
          last_we     = Mem_we_o;
          last_be     = Mem_be_o;
          last_addr   = Mem_addr_o;
          last_wdata  = Mem_wdata_o;
          if (Mem_we_o) wr_cnt++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops expected responses whenever a valid is presented.
  initial begin
    forever begin
      @(negedge clk_i);
      if (MEM_valid_o) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_e = mem_q.pop_front();
          chk("mem_rdata", MEM_rdata_o, mon_e.rdata);
          chk("mem_misalign", {31'd0, Misalign_o}, {31'd0, mon_e.mis});
        end
      end
      if (IF_valid_o) begin
        if (if_q.size() == 0) begin
          chk("if_unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_w = if_q.pop_front();
          chk("if_rdata", IF_rdata_o, mon_w);
        end
      end
    end
  end

  task automatic mem_access(input logic we, input logic [2:0] size, input logic sign,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_mis,
                            output int valid_k, output int req_k);
    mresp_t e;
    @(negedge clk_i);
    e.rdata = exp_rdata;
    e.mis   = exp_mis;
    mem_q.push_back(e);
    MEM_req_i   = 1'b1;
    MEM_we_i    = we;
    MEM_size_i  = size;
    MEM_sign_i  = sign;
    MEM_addr_i  = addr;
    MEM_wdata_i = wdata;
    valid_k = -1;
    req_k   = 0;
    #1;
    for (int k = 0; k < 40 && valid_k < 0; k++) begin
      if (k > 0) @(negedge clk_i);
      if (Mem_req_o) req_k++;
      if (MEM_valid_o) valid_k = k;
    end
    MEM_req_i = 1'b0;
  endtask

  task automatic if_fetch(input logic [31:0] addr, input logic [31:0] exp_word,
                          output int valid_k, output int req_k, output int bad);
    @(negedge clk_i);
    if_q.push_back(exp_word);
    IF_req_i  = 1'b1;
    IF_addr_i = addr;
    valid_k = -1;
    req_k   = 0;
    bad     = 0;
    #1;
    for (int k = 0; k < 40 && valid_k < 0; k++) begin
      if (k > 0) @(negedge clk_i);
      if (Mem_req_o) begin
        req_k++;
        if (Mem_addr_o !== {addr[31:2], 2'b00} || Mem_be_o !== 4'hF || Mem_we_o !== 1'b0) bad++;
      end
      if (IF_valid_o) valid_k = k;
    end
    IF_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vk, rk, bad, wr0, seen_valid, seen_req;
    mem_img[32'h200] = 32'h80FF1234;
    mem_img[32'h300] = 32'hDEADBEEF;
    mem_img[32'h400] = 32'hCAFEF00D;
    mem_img[32'h500] = 32'h13579BDF;

    rst_i = 1'b1;
    IF_req_i = 1'b0; IF_addr_i = '0;
    MEM_req_i = 1'b0; MEM_we_i = 1'b0; MEM_addr_i = '0;
    MEM_size_i = Word; MEM_sign_i = Unsigned; MEM_wdata_i = '0;
    repeat (2) @(negedge clk_i);
    chk_outputs_zero("reset");
    rst_i = 1'b0;

    // Both requests together: data first, fetch granted in the following IDLE
    @(negedge clk_i);
    mon_e.rdata = 32'hCAFEF00D;
    mon_e.mis   = 1'b0;
    mem_q.push_back(mon_e);
    if_q.push_back(32'h80FF1234);
    IF_req_i = 1'b1; IF_addr_i = 32'h201;
    MEM_req_i = 1'b1; MEM_we_i = 1'b0; MEM_size_i = Word; MEM_sign_i = Unsigned;
    MEM_addr_i = 32'h400;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk_i);
      chk($sformatf("both_c%0d", k),
          {27'd0, MEM_valid_o, IF_valid_o, Mem_req_o, Stall_IF_o, Stall_MEM_o},
          {27'd0, both_exp[k]});
      if (MEM_valid_o) MEM_req_i = 1'b0;
      if (IF_valid_o) IF_req_i = 1'b0;
    end
    MEM_req_i = 1'b0;
    IF_req_i  = 1'b0;

    mem_access(1'b1, Byte, Unsigned, 32'h103, 32'h000000A5, 32'd0, 1'b0, vk, rk);
    chk("sb_valid_k", vk, 2);
    chk("sb_addr", last_addr, 32'h100);
    chk("sb_be", {28'd0, last_be}, 32'h8);
    chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
    chk("sb_we", {31'd0, last_we}, 32'd1);

    mem_access(1'b1, Half, Unsigned, 32'h502, 32'hFFFF1234, 32'd0, 1'b0, vk, rk);
    chk("sh_be", {28'd0, last_be}, 32'hC);
    chk("sh_wdata", last_wdata, 32'h12341234);

    mem_access(1'b1, Word, Unsigned, 32'h600, 32'h0BADF00D, 32'd0, 1'b0, vk, rk);
    chk("sw_be", {28'd0, last_be}, 32'hF);
    chk("sw_wdata", last_wdata, 32'h0BADF00D);

    mem_access(1'b0, Half, Signed, 32'h202, 32'd0, 32'hFFFF80FF, 1'b0, vk, rk);
    chk("lh_addr", last_addr, 32'h200);
    chk("lh_be", {28'd0, last_be}, 32'hC);
    mem_access(1'b0, Half, Unsigned, 32'h202, 32'd0, 32'h000080FF, 1'b0, vk, rk);
    mem_access(1'b0, Byte, Signed, 32'h401, 32'd0, 32'hFFFFFFF0, 1'b0, vk, rk);
    mem_access(1'b0, Byte, Unsigned, 32'h403, 32'd0, 32'h000000CA, 1'b0, vk, rk);
    chk("lbu_req_cycles", rk, 1);

    // Fetch with three memory wait cycles
    mem_wait = 3;
    if_fetch(32'h502, 32'h13579BDF, vk, rk, bad);
    chk("fetch_req_cycles", rk, 4);
    chk("fetch_req_stable", bad, 0);
    chk("fetch_valid_k", vk, 5);
    mem_wait = 0;

    wr0 = wr_cnt;
`ifdef MISALIGN_CHECK_EN
    mem_access(1'b0, Word, Unsigned, 32'h301, 32'd0, 32'd0, 1'b1, vk, rk);
    chk("mis_valid_k", vk, 1);
    chk("mis_req_cycles", rk, 0);
    mem_access(1'b1, Half, Unsigned, 32'h305, 32'h00001111, 32'd0, 1'b1, vk, rk);
    chk("mis_st_req_cycles", rk, 0);
    chk("mis_no_write", wr_cnt, wr0);
`else
    mem_access(1'b0, Word, Unsigned, 32'h301, 32'd0, 32'hDEADBEEF, 1'b0, vk, rk);
    chk("nomis_valid_k", vk, 2);
    chk("nomis_addr", last_addr, 32'h300);
    chk("nomis_be", {28'd0, last_be}, 32'hF);
    chk("nomis_no_write", wr_cnt, wr0);
`endif

    // Reset while a data access waits on a slow memory
    mem_wait = 6;
    @(negedge clk_i);
    MEM_req_i = 1'b1; MEM_we_i = 1'b0; MEM_size_i = Word; MEM_sign_i = Unsigned;
    MEM_addr_i = 32'h600;
    repeat (2) @(negedge clk_i);
    chk("rstmid_req_before", {31'd0, Mem_req_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1 chk_outputs_zero("rstmid");
    #1 rst_i = 1'b0;
    MEM_req_i = 1'b0;
    seen_valid = 0;
    seen_req   = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (MEM_valid_o) seen_valid++;
      if (Mem_req_o) seen_req++;
    end
    chk("rstmid_no_valid", seen_valid, 0);
    chk("rstmid_no_req", seen_req, 0);
    mem_wait = 0;

    repeat (2) @(negedge clk_i);
    chk("mem_q_empty", mem_q.size(), 0);
    chk("if_q_empty", if_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
